// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_pkg
// Brief   : Shared types and constants for the instruction-fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int          c_hold_w    = 3;
    localparam logic [2:0]  c_hold_if   = 3'd2;
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_gnrl_dff.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_gnrl_dff
// Brief   : Write-enabled register with a programmable reset value.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_gnrl_dff #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] data_r_ini,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= data_r_ini;
        end else if (wr_en) begin
            data_out <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : PC generation, single-outstanding instruction fetch and 1-entry
//           output buffer feeding the IF/ID register, with redirect handling.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [c_hold_w-1:0] hold_code,
    input  logic                jump_en,
    input  logic [31:0]         jump_addr,
    output logic                mem_req_o,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic [31:0]         addr_instr_o,
    output logic [31:0]         instr_o
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic         r_out_valid;
    logic [31:0]  r_out_addr;
    logic [31:0]  r_out_instr;

    logic         w_hold;
    logic         w_allow;
    logic         w_fill;
    logic         w_valid_we;

    assign w_hold  = (hold_code >= c_hold_if);
    // Only issue when the buffer is guaranteed free by the time data returns.
    assign w_allow = jump_en | ~r_out_valid | ~w_hold;

    assign mem_req_o  = rst_n & (r_state == S_REQ) & w_allow;
    assign mem_addr_o = word_align(jump_en ? jump_addr : r_pc);

    assign w_fill     = (r_state == S_WAIT) & mem_rvalid_i & ~jump_en;
    assign w_valid_we = w_fill | jump_en | ~w_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (mem_req_o && mem_gnt_i) begin
                        r_req_addr <= mem_addr_o;
                        r_state    <= S_WAIT;
                    end else if (jump_en) begin
                        r_pc <= jump_addr;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_pc    <= jump_en ? jump_addr : (r_req_addr + 32'd4);
                        r_state <= S_REQ;
                    end else if (jump_en) begin
                        r_pc    <= jump_addr;
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // Response in flight belongs to the abandoned path.
                    if (jump_en) begin
                        r_pc <= jump_addr;
                    end
                    if (mem_rvalid_i) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    instr_fetch_gnrl_dff #(.DW(1)) u_out_valid (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (w_valid_we),
        .data_r_ini (1'b0),
        .data_in    (w_fill),
        .data_out   (r_out_valid)
    );

    instr_fetch_gnrl_dff #(.DW(32)) u_out_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (w_fill),
        .data_r_ini (32'h0000_0000),
        .data_in    (r_req_addr),
        .data_out   (r_out_addr)
    );

    instr_fetch_gnrl_dff #(.DW(32)) u_out_instr (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (w_fill),
        .data_r_ini (NOP_INSTR),
        .data_in    (mem_rdata_i),
        .data_out   (r_out_instr)
    );

    assign addr_instr_o = r_out_addr;
    assign instr_o      = r_out_valid ? r_out_instr : NOP_INSTR;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Self-checking bench: directed vector table, reset sequence and
//           randomized traffic against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  hold_code = 3'd0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    logic        mem_req_o, mem_req1;
    logic [31:0] mem_addr_o, mem_addr1;
    logic [31:0] addr_instr_o, addr_instr1;
    logic [31:0] instr_o, instr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .hold_code(hold_code),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .addr_instr_o(addr_instr_o), .instr_o(instr_o)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .hold_code(hold_code),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_req_o(mem_req1), .mem_addr_o(mem_addr1),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .addr_instr_o(addr_instr1), .instr_o(instr1)
    );

    typedef struct {
        logic [2:0]  hc;
        logic        j;
        logic [31:0] ja;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_ainstr;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic [2:0] hc, input logic j, input logic [31:0] ja,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_instr, input logic [31:0] e_ainstr);
        vec_t v;
        v.hc = hc; v.j = j; v.ja = ja; v.g = g; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_ainstr = e_ainstr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] hc, input logic j, input logic [31:0] ja,
                         input logic g, input logic rv, input logic [31:0] rd);
        hold_code = hc; jump_en = j; jump_addr = ja;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: transaction-level view of the fetch stage
    logic [31:0] m_pc, m_last, m_inflight;
    logic        m_out, m_wrong;
    logic [31:0] buf_q[$];

    initial begin
        // Zero-wait fetch, hold, redirect-on-grant, redirect-in-wait, unaligned target
        tbl[0]  = mk(0, 0, 0,      1, 0, 0,            1, 32'h000, NOP,          32'h000);
        tbl[1]  = mk(0, 0, 0,      0, 1, 32'hA5A50000, 0, 0,       NOP,          32'h000);
        tbl[2]  = mk(0, 0, 0,      1, 0, 0,            1, 32'h004, 32'hA5A50000, 32'h000);
        tbl[3]  = mk(0, 0, 0,      0, 1, 32'hA5A50004, 0, 0,       NOP,          32'h000);
        tbl[4]  = mk(0, 0, 0,      1, 0, 0,            1, 32'h008, 32'hA5A50004, 32'h004);
        tbl[5]  = mk(0, 0, 0,      0, 1, 32'hA5A50008, 0, 0,       NOP,          32'h004);
        for (int k = 6; k <= 10; k++)
            tbl[k] = mk(3'd2, 0, 0, 1, 0, 0,           0, 0,       32'hA5A50008, 32'h008);
        tbl[11] = mk(0, 0, 0,      1, 0, 0,            1, 32'h00C, 32'hA5A50008, 32'h008);
        tbl[12] = mk(0, 0, 0,      0, 1, 32'hA5A5000C, 0, 0,       NOP,          32'h008);
        tbl[13] = mk(0, 1, 32'h100,1, 0, 0,            1, 32'h100, 32'hA5A5000C, 32'h00C);
        tbl[14] = mk(0, 0, 0,      0, 1, 32'hA5A50100, 0, 0,       NOP,          32'h00C);
        tbl[15] = mk(0, 0, 0,      1, 0, 0,            1, 32'h104, 32'hA5A50100, 32'h100);
        tbl[16] = mk(0, 0, 0,      0, 1, 32'hA5A50104, 0, 0,       NOP,          32'h100);
        tbl[17] = mk(0, 0, 0,      1, 0, 0,            1, 32'h108, 32'hA5A50104, 32'h104);
        tbl[18] = mk(0, 1, 32'h200,0, 0, 0,            0, 0,       NOP,          32'h104);
        tbl[19] = mk(0, 0, 0,      1, 0, 0,            0, 0,       NOP,          32'h104);
        tbl[20] = mk(0, 0, 0,      0, 0, 0,            0, 0,       NOP,          32'h104);
        tbl[21] = mk(0, 0, 0,      0, 1, 32'hDEADBEEF, 0, 0,       NOP,          32'h104);
        tbl[22] = mk(0, 0, 0,      1, 0, 0,            1, 32'h200, NOP,          32'h104);
        tbl[23] = mk(0, 0, 0,      0, 1, 32'hA5A50200, 0, 0,       NOP,          32'h104);
        tbl[24] = mk(0, 0, 0,      0, 0, 0,            1, 32'h204, 32'hA5A50200, 32'h200);
        tbl[25] = mk(0, 1, 32'h203,0, 0, 0,            1, 32'h200, NOP,          32'h200);
        tbl[26] = mk(0, 0, 0,      1, 0, 0,            1, 32'h200, NOP,          32'h200);
        tbl[27] = mk(0, 0, 0,      0, 1, 32'hA5A50200, 0, 0,       NOP,          32'h200);
        tbl[28] = mk(0, 0, 0,      1, 0, 0,            1, 32'h204, 32'hA5A50200, 32'h200);

        #3;
        chk("reset_req", {31'b0, mem_req_o}, 32'h0);
        chk("reset_addr_instr", addr_instr_o, 32'h0);
        chk("reset_instr", instr_o, NOP);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i].hc, tbl[i].j, tbl[i].ja, tbl[i].g, tbl[i].rv, tbl[i].rd);
            chk($sformatf("vec%0d_req", i), {31'b0, mem_req_o}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("vec%0d_addr", i), mem_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d_instr", i), instr_o, tbl[i].e_instr);
            chk($sformatf("vec%0d_addr_instr", i), addr_instr_o, tbl[i].e_ainstr);
            if (i == 0) begin
                chk("wrap_req0", {31'b0, mem_req1}, 32'h1);
                chk("wrap_addr0", mem_addr1, 32'hFFFF_FFFC);
            end
            if (i == 2) begin
                chk("wrap_addr1", mem_addr1, 32'h0000_0000);
                chk("wrap_instr", instr1, 32'hA5A50000);
                chk("wrap_addr_instr", addr_instr1, 32'hFFFF_FFFC);
            end
            tick();
        end

        // Asynchronous reset while a request is outstanding
        apply(0, 0, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("async_rst_addr_instr", addr_instr_o, 32'h0);
        chk("async_rst_instr", instr_o, NOP);
        tick();
        chk("rst_held_req", {31'b0, mem_req_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 1, 0, 0);
        chk("post_rst_req", {31'b0, mem_req_o}, 32'h1);
        chk("post_rst_addr", mem_addr_o, 32'h0);

        // Randomized traffic against the reference model
        m_pc = 32'h0; m_last = 32'h0; m_inflight = 32'h0;
        m_out = 1'b0; m_wrong = 1'b0;
        buf_q.delete();
        for (int n = 0; n < 600; n++) begin
            logic        h, j, g, rv, e_req, resp, fill;
            logic [2:0]  hc;
            logic [31:0] ja, rd, e_addr, e_instr;
            h  = ($urandom % 3 == 0);
            hc = h ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            j  = ($urandom % 10 == 0);
            ja = $urandom;
            g  = $urandom % 2;
            rv = m_out && ($urandom % 2 == 1);
            rd = $urandom;
            apply(hc, j, ja, g, rv, rd);

            e_req   = !m_out && (j || buf_q.size() == 0 || !h);
            e_addr  = (j ? ja : m_pc) & ~32'h3;
            e_instr = (buf_q.size() != 0) ? buf_q[0] : NOP;
            chk("rnd_req", {31'b0, mem_req_o}, {31'b0, e_req});
            if (e_req) chk("rnd_addr", mem_addr_o, e_addr);
            chk("rnd_instr", instr_o, e_instr);
            chk("rnd_addr_instr", addr_instr_o, m_last);

            resp = m_out && rv;
            fill = resp && !m_wrong && !j;
            if (j || !h) buf_q.delete();
            if (j) m_pc = ja;
            if (fill) begin
                buf_q.delete();
                buf_q.push_back(rd);
                m_last = m_inflight;
                m_pc   = m_inflight + 32'd4;
            end
            if (resp) m_out = 1'b0;
            else if (m_out && j) m_wrong = 1'b1;
            if (e_req && g) begin
                m_out = 1'b1;
                m_wrong = 1'b0;
                m_inflight = e_addr;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
